// File: rtl/hex_scan_ctrl_pkg.sv
// Shared constants and seven-segment font for the display blocks.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package hex_scan_ctrl_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;
    localparam int         NUM_DIGITS = 8;

    function automatic logic [6:0] seg7_font(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Writer-side bus of the scan controller: digit writes and the per-digit enable mask.
// No backpressure: every write is accepted in the cycle it is presented.
interface hex_scan_ctrl_if;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        wr_all_en;
    logic [31:0] wr_all_data;
    logic [7:0]  digit_en;

    modport master (
        output wr_en, wr_addr, wr_data, wr_all_en, wr_all_data, digit_en
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_all_en, wr_all_data, digit_en
    );
endinterface

// File: rtl/hex_scan_ctrl_hex7seg_decode.sv
// Combinational 4-bit hex value to active-low seven-segment pattern.
// Zero latency; no flow control.
module hex7seg_decode
    import hex_scan_ctrl_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);
    assign seg = seg7_font(val);
endmodule

// File: rtl/hex_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan with per-slot dead-time blanking.
// Outputs registered, 1-cycle latency from (cnt, idx); writes never stall.
module hex_scan_ctrl
    import hex_scan_ctrl_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    hex_scan_ctrl_if.slave       bus,
    output logic [6:0]           hex,
    output logic [7:0]           hex_on,
    output logic                 frame_tick
);
    localparam int             CW      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    generate
        if (DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_param_check
            $error("hex_scan_ctrl: need DIV >= 2 and 0 <= BLANK < DIV");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [3:0]    digits [NUM_DIGITS];
    logic          slot_end;
    logic          wrap;
    logic          show;
    logic [6:0]    seg_cur;

    assign slot_end = (cnt == CNT_MAX);
    assign wrap     = slot_end && (idx == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Bulk load wins over a single-digit write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'h0;
        end else if (bus.wr_all_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= bus.wr_all_data[4*i +: 4];
        end else if (bus.wr_en) begin
            digits[bus.wr_addr] <= bus.wr_data;
        end
    end

    hex7seg_decode u_decode (
        .val (digits[idx]),
        .seg (seg_cur)
    );

    // Anode stays off during the dead-time window so the old digit never ghosts.
    assign show = bus.digit_en[idx] && !(int'(cnt) < BLANK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex        <= SEG_OFF;
            hex_on     <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            hex        <= show ? seg_cur : SEG_OFF;
            hex_on     <= show ? ~(8'b1 << idx) : AN_OFF;
            frame_tick <= wrap;
        end
    end

endmodule
